// File: rtl/lat_meter.sv
// ============================================================================
// Module   : lat_meter
// Brief    : Start-to-first-response latency meter over CH response lines.
//            Optional LAT_MAX_EN macro adds the max_lat running maximum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lat_meter #(
    parameter int CH      = 4,
    parameter int CW      = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                                 clk_in,
    input  logic                                 reset,
    input  logic [CH:0]                          in,
    output logic [CW-1:0]                        out,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ch_id,
    output logic                                 done,
    output logic                                 timeout,
    output logic                                 busy
`ifdef LAT_MAX_EN
    ,
    output logic [CW-1:0]                        max_lat
`endif
);

    localparam int            IDW       = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CH:0]     r_sin;
    logic [CH:0]     r_sprev;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_out;
    logic [IDW-1:0]  r_ch_id;
    logic            r_done;
    logic            r_timeout;
    logic            r_busy;
`ifdef LAT_MAX_EN
    logic [CW-1:0]   r_max_lat;
`endif

    logic [CH:0]     w_edge;
    logic            w_any;
    logic [IDW-1:0]  w_idx;

    // Both stages reset high so a line already high at reset release is not an edge.
    assign w_edge = r_sin & ~r_sprev;

    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (w_edge[i+1]) begin
                w_any = 1'b1;
                w_idx = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sin     <= '1;
            r_sprev   <= '1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_out     <= '0;
            r_ch_id   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
`ifdef LAT_MAX_EN
            r_max_lat <= '0;
`endif
        end else begin
            r_sin   <= in;
            r_sprev <= r_sin;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge[0]) begin
                        r_state <= ST_COUNT;
                        r_cnt   <= CW'(1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    // A response in the final counting cycle still beats the timeout.
                    if (w_any) begin
                        r_out     <= r_cnt;
                        r_ch_id   <= w_idx;
                        r_timeout <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
`ifdef LAT_MAX_EN
                        if (r_cnt > r_max_lat) begin
                            r_max_lat <= r_cnt;
                        end
`endif
                    end else if (r_cnt == C_TIMEOUT) begin
                        r_out     <= '1;
                        r_ch_id   <= '0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out     = r_out;
    assign ch_id   = r_ch_id;
    assign done    = r_done;
    assign timeout = r_timeout;
    assign busy    = r_busy;
`ifdef LAT_MAX_EN
    assign max_lat = r_max_lat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lat_meter.sv
// ============================================================================
// Module   : tb_lat_meter
// Brief    : Randomised self-checking bench for lat_meter (CH=4, CW=8,
//            TIMEOUT=200); checks max_lat when LAT_MAX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lat_meter;

    localparam int CH      = 4;
    localparam int CW      = 8;
    localparam int TIMEOUT = 200;

    logic          clk_in = 1'b0;
    logic          reset;
    logic [CH:0]   in;
    logic [CW-1:0] out;
    logic [1:0]    ch_id;
    logic          done;
    logic          timeout;
    logic          busy;
`ifdef LAT_MAX_EN
    logic [CW-1:0] max_lat;
`endif

    lat_meter #(.CH(CH), .CW(CW), .TIMEOUT(TIMEOUT)) u_dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .in      (in),
        .out     (out),
        .ch_id   (ch_id),
        .done    (done),
        .timeout (timeout),
        .busy    (busy)
`ifdef LAT_MAX_EN
        ,
        .max_lat (max_lat)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: the last reported result, as seen from the pins.
    int m_out = 0;
    int m_ch  = 0;
    int m_to  = 0;
    int m_max = 0;

    int r_off [CH];
    int rtrig;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_results();
        chk("out", 32'(out), 32'(m_out));
        chk("ch_id", 32'(ch_id), 32'(m_ch));
        chk("timeout", 32'(timeout), 32'(m_to));
`ifdef LAT_MAX_EN
        chk("max_lat", 32'(max_lat), 32'(m_max));
`endif
    endtask

    task automatic set_offs(input int a, input int b, input int c, input int d, input int rt);
        r_off[0] = a;
        r_off[1] = b;
        r_off[2] = c;
        r_off[3] = d;
        rtrig    = rt;
    endtask

    // One measurement: start pin rises now; channel ch rises r_off[ch] cycles later
    // (-1 = never). Responses at offset 0 coincide with the start and do not count.
    task automatic run_meas();
        int lat;
        int chx;
        bit to;
        lat = 0;
        chx = 0;
        for (int c = 0; c < CH; c++) begin
            if (r_off[c] >= 1 && r_off[c] <= TIMEOUT && (lat == 0 || r_off[c] < lat)) begin
                lat = r_off[c];
                chx = c;
            end
        end
        to = (lat == 0);
        if (to) lat = TIMEOUT;

        in[0] = 1'b1;
        for (int c = 0; c < CH; c++) if (r_off[c] == 0) in[c+1] = 1'b1;

        for (int t = 1; t <= lat + 3; t++) begin
            @(negedge clk_in);
            if (t == lat + 2) begin
                m_out = to ? 255 : lat;
                m_ch  = to ? 0 : chx;
                m_to  = to ? 1 : 0;
                if (!to && lat > m_max) m_max = lat;
            end
            chk("done", 32'(done), (t == lat + 2) ? 32'd1 : 32'd0);
            chk("busy", 32'(busy), (t >= 2 && t <= lat + 1) ? 32'd1 : 32'd0);
            chk_results();
            for (int c = 0; c < CH; c++) if (r_off[c] == t) in[c+1] = 1'b1;
            if (rtrig >= 1 && t == rtrig)     in[0] = 1'b0;
            if (rtrig >= 1 && t == rtrig + 1) in[0] = 1'b1;
        end
        in = '0;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk_in);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int lat_r;
        reset = 1'b1;
        in    = '0;
        repeat (5) @(negedge clk_in);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_ch_id", 32'(ch_id), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Lines high through reset must not start a measurement.
        in = 5'b00011;
        @(negedge clk_in);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            chk("held_busy", 32'(busy), 32'd0);
            chk("held_done", 32'(done), 32'd0);
        end
        in = '0;
        repeat (2) @(negedge clk_in);

        set_offs(-1, 3, -1, -1, -1);   run_meas();
        set_offs(-1, -1, -1, 50, -1);  run_meas();
        set_offs(10, -1, 10, -1, -1);  run_meas();
        set_offs(-1, -1, 7, -1, 4);    run_meas();
        set_offs(-1, -1, -1, -1, -1);  run_meas();
        set_offs(-1, 200, -1, -1, -1); run_meas();
        set_offs(0, -1, 5, -1, -1);    run_meas();

        // Abort a measurement with reset around cnt=20.
        in[0] = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            @(negedge clk_in);
            chk("abort_busy", 32'(busy), (t >= 2) ? 32'd1 : 32'd0);
            chk("abort_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk_in);
        m_out = 0; m_ch = 0; m_to = 0; m_max = 0;
        chk("abort_busy_rst", 32'(busy), 32'd0);
        chk("abort_done_rst", 32'(done), 32'd0);
        chk_results();
        reset = 1'b0;
        in    = '0;
        repeat (3) begin
            @(negedge clk_in);
            chk("post_abort_done", 32'(done), 32'd0);
        end
        set_offs(4, -1, -1, -1, -1);   run_meas();

        // Running maximum sequence: 3, 9, 5, timeout.
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        m_out = 0; m_ch = 0; m_to = 0; m_max = 0;
        @(negedge clk_in);
        set_offs(3, -1, -1, -1, -1);   run_meas();
        set_offs(-1, 9, -1, -1, -1);   run_meas();
        set_offs(-1, -1, 5, -1, -1);   run_meas();
        set_offs(-1, -1, -1, -1, -1);  run_meas();

        for (int s = 0; s < 25; s++) begin
            int mn;
            mn = 0;
            for (int c = 0; c < CH; c++) begin
                int p;
                p = int'($urandom_range(0, 9));
                if (p == 0)      r_off[c] = -1;
                else if (p == 1) r_off[c] = 0;
                else if (p == 2) r_off[c] = int'($urandom_range(150, 210));
                else             r_off[c] = int'($urandom_range(1, 40));
                if (r_off[c] >= 1 && r_off[c] <= TIMEOUT && (mn == 0 || r_off[c] < mn)) mn = r_off[c];
            end
            lat_r = (mn == 0) ? TIMEOUT : mn;
            rtrig = (lat_r >= 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, lat_r - 2)) : -1;
            run_meas();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/lat_meter.md
# lat_meter

Parametrised latency-measurement FSM, successor to the 5-in/8-out latency test block. It timestamps a rising edge on a start line and measures, in clock cycles, how long until the first rising edge on any of CH response lines. It reports the latency, the responding channel and a timeout flag. It sits between the pad inputs and the 8-bit output bus of the test harness. Unlike its predecessor it supports N channels, configurable counter width and timeout, and optional max tracking.

## Interface
- CH, 4, number of response channels (1..16)
- CW, 8, latency counter / result width
- TIMEOUT, 200, max cycles to wait for a response; must satisfy 1 ≤ TIMEOUT ≤ 2^CW − 2
- clk_in  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- in  in  CH+1  in[0] = start line; in[CH:1] = response lines 0..CH−1
- out  out  CW  last measured latency (all-ones on timeout)
- ch_id  out  max(1,$clog2(CH))  index of responding channel
- done  out  1  one-cycle pulse when out/ch_id/timeout update
- timeout  out  1  1 if last measurement timed out
- busy  out  1  1 while a measurement is in progress
- max_lat  out  CW  present only with LAT_MAX_EN; largest non-timeout latency since reset

## Operation
- Input stage: in → s_in → s_prev registers, both reset to all-ones. Edge[i] = s_in[i] & ~s_prev[i]. A line held high through reset produces no edge; only genuine low→high transitions count.
- States:
  - IDLE: busy=0. On the start edge, go to COUNT with cnt=1. Response edges are ignored.
  - COUNT: busy=1, cnt increments each cycle.
    - If any response edge: capture out=cnt, ch_id=lowest index with an edge, timeout=0, then go to DONE.
    - Else if cnt==TIMEOUT: capture out={CW{1}}, ch_id=0, timeout=1, then go to DONE.
    - Start edges in COUNT are ignored; they do not restart the measurement.
  - DONE: done=1, busy=0. Always go to IDLE next cycle. Start/response edges in DONE are ignored.
- Results hold until the next capture.
- Simultaneous events:
  - Start and response edges in the same IDLE cycle: the response is ignored, and the measurement starts.
  - Response edge in the cycle where cnt==TIMEOUT: the response wins (out=TIMEOUT, timeout=0).
  - Several channels edge together: the lowest index wins.
- Latency definition: if the start and response pins rise k cycles apart (k≥1, synchronous to clk_in), out=k. Both paths share the same two-stage input pipeline, so the fixed input delay cancels.
- Reset mid-measurement: state returns to IDLE, all outputs and max_lat clear, and s_in/s_prev reload all-ones. No done is emitted for the aborted run.

## Timing
- Reset values: out=0, ch_id=0, done=0, timeout=0, busy=0, max_lat=0, state=IDLE, cnt=0.
- A pin edge before clock edge E0 is seen as an edge in the cycle after E0. If that edge is the start edge, COUNT begins on the following cycle.
- Capture happens at the clock edge ending the detecting COUNT cycle. In the next cycle (DONE), done=1 and the new out/ch_id/timeout values are visible together.
- Minimum latency is 1. Timeout is reported in the cycle after cnt==TIMEOUT.
- The earliest next start edge accepted is in the first IDLE cycle after DONE.
- cnt never wraps, because TIMEOUT < 2^CW − 1.

## Configuration
- LAT_MAX_EN defined:
  - max_lat port and register are present.
  - On each non-timeout capture, max_lat ← max(max_lat, cnt). Timeouts never update it.
  - Cleared by reset.
- LAT_MAX_EN undefined: no max_lat port and no comparator. All other behaviour is identical.

## Test plan
All scenarios use CH=4, CW=8, TIMEOUT=200.
- Reset: hold reset 5 cycles with in=0 → out=0, ch_id=0, done=0, timeout=0, busy=0. Hold in=5'b00011 through reset, then release → no measurement starts, busy stays 0.
- Basic measurement: in[0] rises, in[2] rises 3 cycles later → busy high, then a single done pulse with out=3, ch_id=1, timeout=0. Then in[0] rises, in[4] rises 50 cycles later → out=50 (8'h32), ch_id=3.
- Priority and re-trigger:
  - in[1] and in[3] rise in the same cycle, 10 cycles after start → out=10, ch_id=0.
  - in[0] toggles again 5 cycles into COUNT, response comes at 7 → out=7.
- Timeout: start with no response edge → done pulse after exactly 201 cycles in COUNT/DONE, with out=8'hFF and timeout=1. A response edge exactly at cnt=200 → out=200 (8'hC8), timeout=0.
- Reset mid-COUNT: assert reset at cnt=20 → no done pulse and all outputs 0. A following 4-cycle measurement reports out=4.
- LAT_MAX_EN: run measurements of 3, 9, 5, then a timeout → max_lat goes 3, 9, 9, 9. With the macro undefined, the bench compiles without the max_lat port.
